// File: rtl/execute_writeback_if.sv
// ----------------------------------------------------------------------------
// execute_writeback_if
//   Bundles the decode -> execute instruction handshake and the execute ->
//   register-file writeback bus of the venus pipeline.
//
//   Decode side (driven by master):
//     i_v        instruction valid
//     i_opecode  opcode
//     i_opr0     operand 0 (rd/rs value)
//     i_opr1     operand 1 (register or extended immediate)
//     i_wb_r     destination register
//   Execute side (driven by slave):
//     o_stall    hold decode output register (combinational)
//     o_wb       writeback strobe (registered)
//     o_wb_r     writeback register (registered)
//     o_result   writeback data (registered)
// ----------------------------------------------------------------------------
interface execute_writeback_if #(
    parameter int W_OPC = 7,
    parameter int W_RD  = 4,
    parameter int W_OPR = 32
);
    logic             i_v;
    logic [W_OPC-1:0] i_opecode;
    logic [W_OPR-1:0] i_opr0;
    logic [W_OPR-1:0] i_opr1;
    logic [W_RD-1:0]  i_wb_r;
    logic             o_stall;
    logic             o_wb;
    logic [W_RD-1:0]  o_wb_r;
    logic [W_OPR-1:0] o_result;

    modport master (
        output i_v, i_opecode, i_opr0, i_opr1, i_wb_r,
        input  o_stall, o_wb, o_wb_r, o_result
    );

    modport slave (
        input  i_v, i_opecode, i_opr0, i_opr1, i_wb_r,
        output o_stall, o_wb, o_wb_r, o_result
    );
endinterface

// File: rtl/execute_writeback.sv
// ----------------------------------------------------------------------------
// execute_writeback
//   Execute/writeback stage of the venus pipeline. Single-cycle ALU ops write
//   back one cycle after acceptance. MUL/DIVU/REMU run on a shared iterative
//   N_ITER-step engine (shift-add multiply, restoring divide) and hold decode
//   through o_stall while busy. Every accepted instruction, including
//   undefined opcodes, produces exactly one writeback so the destination
//   reservation in decode is always released.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    execute_writeback_if.slave (decode handshake + writeback bus)
// ----------------------------------------------------------------------------
module execute_writeback #(
    parameter int W_OPC  = 7,
    parameter int W_RD   = 4,
    parameter int W_OPR  = 32,
    parameter int N_ITER = 32
) (
    input  logic                clk,
    input  logic                reset,
    execute_writeback_if.slave  bus
);

    localparam int W_SH  = $clog2(W_OPR);
    localparam int W_CNT = $clog2(N_ITER);

    localparam logic [W_OPC-1:0] OP_ADD  = W_OPC'(7'h01);
    localparam logic [W_OPC-1:0] OP_SUB  = W_OPC'(7'h02);
    localparam logic [W_OPC-1:0] OP_AND  = W_OPC'(7'h03);
    localparam logic [W_OPC-1:0] OP_OR   = W_OPC'(7'h04);
    localparam logic [W_OPC-1:0] OP_XOR  = W_OPC'(7'h05);
    localparam logic [W_OPC-1:0] OP_SLL  = W_OPC'(7'h06);
    localparam logic [W_OPC-1:0] OP_SRL  = W_OPC'(7'h07);
    localparam logic [W_OPC-1:0] OP_SRA  = W_OPC'(7'h08);
    localparam logic [W_OPC-1:0] OP_MOV  = W_OPC'(7'h09);
    localparam logic [W_OPC-1:0] OP_MUL  = W_OPC'(7'h0A);
    localparam logic [W_OPC-1:0] OP_DIVU = W_OPC'(7'h0B);
    localparam logic [W_OPC-1:0] OP_REMU = W_OPC'(7'h0C);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [W_CNT-1:0]   r_cnt;
    logic [W_OPC-1:0]   r_op;
    logic [W_RD-1:0]    r_rd;
    // r_a: multiplier (shifts right) / dividend, becoming the quotient (shifts left)
    // r_b: multiplicand (shifts left) / divisor (constant)
    // r_acc: product accumulator / partial remainder
    logic [W_OPR-1:0]   r_a;
    logic [W_OPR-1:0]   r_b;
    logic [W_OPR-1:0]   r_acc;

    logic               r_wb;
    logic [W_RD-1:0]    r_wb_r;
    logic [W_OPR-1:0]   r_result;

    logic               w_is_multi;
    logic               w_accept;
    logic               w_stall;
    logic [W_SH-1:0]    w_sh;
    logic [W_OPR-1:0]   w_alu;
    logic [W_OPR:0]     w_rem_sh;
    logic [W_OPR:0]     w_rem_diff;
    logic               w_rem_ge;
    logic [W_OPR-1:0]   w_multi_res;

    assign w_is_multi = (bus.i_opecode == OP_MUL) ||
                        (bus.i_opecode == OP_DIVU) ||
                        (bus.i_opecode == OP_REMU);
    assign w_accept   = (r_state == S_IDLE) && bus.i_v;
    assign w_sh       = bus.i_opr1[W_SH-1:0];

    // Single-cycle ALU
    always_comb begin
        w_alu = bus.i_opr0;
        case (bus.i_opecode)
            OP_ADD:  w_alu = bus.i_opr0 + bus.i_opr1;
            OP_SUB:  w_alu = bus.i_opr0 - bus.i_opr1;
            OP_AND:  w_alu = bus.i_opr0 & bus.i_opr1;
            OP_OR:   w_alu = bus.i_opr0 | bus.i_opr1;
            OP_XOR:  w_alu = bus.i_opr0 ^ bus.i_opr1;
            OP_SLL:  w_alu = bus.i_opr0 << w_sh;
            OP_SRL:  w_alu = bus.i_opr0 >> w_sh;
            OP_SRA:  w_alu = W_OPR'($signed(bus.i_opr0) >>> w_sh);
            OP_MOV:  w_alu = bus.i_opr1;
            default: w_alu = bus.i_opr0;
        endcase
    end

    // Restoring-divide step: the borrow bit of the W_OPR+1 bit subtraction
    // doubles as the "remainder < divisor" flag.
    always_comb begin
        w_rem_sh   = {r_acc, r_a[W_OPR-1]};
        w_rem_diff = w_rem_sh - {1'b0, r_b};
        w_rem_ge   = ~w_rem_diff[W_OPR];
    end

    always_comb begin
        w_multi_res = r_acc;
        case (r_op)
            OP_MUL:  w_multi_res = r_acc;
            OP_DIVU: w_multi_res = r_a;
            default: w_multi_res = r_acc;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_multi) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs. DONE drops stall unconditionally so decode advances past
    // the instruction it was holding; that instruction is never re-accepted.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_accept && w_is_multi;
            S_BUSY:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    // Datapath and registered writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_wb     <= 1'b0;
            r_wb_r   <= '0;
            r_result <= '0;
        end else begin
            r_wb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_multi) begin
                            r_cnt <= W_CNT'(N_ITER - 1);
                            r_op  <= bus.i_opecode;
                            r_rd  <= bus.i_wb_r;
                            r_acc <= '0;
                            if (bus.i_opecode == OP_MUL) begin
                                r_a <= bus.i_opr1;
                                r_b <= bus.i_opr0;
                            end else begin
                                r_a <= bus.i_opr0;
                                r_b <= bus.i_opr1;
                            end
                        end else begin
                            r_wb     <= 1'b1;
                            r_wb_r   <= bus.i_wb_r;
                            r_result <= w_alu;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_op == OP_MUL) begin
                        if (r_a[0]) r_acc <= r_acc + r_b;
                        r_b <= r_b << 1;
                        r_a <= r_a >> 1;
                    end else begin
                        r_acc <= w_rem_ge ? w_rem_diff[W_OPR-1:0] : w_rem_sh[W_OPR-1:0];
                        r_a   <= {r_a[W_OPR-2:0], w_rem_ge};
                    end
                end
                S_DONE: begin
                    r_wb     <= 1'b1;
                    r_wb_r   <= r_rd;
                    r_result <= w_multi_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_stall  = w_stall;
    assign bus.o_wb     = r_wb;
    assign bus.o_wb_r   = r_wb_r;
    assign bus.o_result = r_result;

endmodule
